// File: rtl/moore_seq_detector_param_pkg.sv
// Shared elaboration-time helpers for the serial sequence detectors: state width and
// the KMP-style next-state rule, evaluated only as constant functions.
package moore_seq_detector_param_pkg;

   localparam int MAX_PAT_W = 16;

   function automatic int state_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   // Bit i of the received order: i = 0 is the first bit of the pattern (its MSB).
   function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int pat_w, input int i);
      return pat[pat_w-1-i];
   endfunction

   function automatic int border_len(input logic [MAX_PAT_W-1:0] pat, input int pat_w);
      int  best;
      bit  ok;
      best = 0;
      for (int j = 1; j < pat_w; j++) begin
         ok = 1'b1;
         for (int i = 0; i < j; i++)
            if (pat_bit(pat, pat_w, i) != pat_bit(pat, pat_w, pat_w - j + i)) ok = 1'b0;
         if (ok) best = j;
      end
      return best;
   endfunction

   // Longest pattern prefix that is a suffix of (first `base` pattern bits, b).
   // S_HIT restarts from S_0 or from the pattern border; encodings above PAT_W collapse to S_0.
   function automatic int next_state(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                     input int overlap, input int k, input int b);
      int   base;
      int   best;
      int   idx;
      logic sb;
      bit   ok;
      best = 0;
      base = k;
      if (k == pat_w) base = (overlap != 0) ? border_len(pat, pat_w) : 0;
      if (k <= pat_w) begin
         for (int j = 1; j <= base + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
               idx = base + 1 - j + i;
               sb  = (idx < base) ? pat_bit(pat, pat_w, idx) : logic'(b[0]);
               if (sb != pat_bit(pat, pat_w, i)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Saturating hit counter used when SEQ_DET_CNT_EN is defined.
module seq_det_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore sequence detector; define SEQ_DET_CNT_EN to add the det_count
// saturating hit counter port. Transition table is built entirely at elaboration.
module moore_seq_detector_param
   import moore_seq_detector_param_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter bit               OVERLAP = 1'b0,
   parameter int               CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         data_valid,
   input  logic                         data,
   output logic                         detected,
   output logic [$clog2(PAT_W+1)-1:0]   state_dbg
`ifdef SEQ_DET_CNT_EN
   ,
   output logic [CNT_W-1:0]             det_count
`endif
);

   localparam int            SW    = state_w(PAT_W);
   localparam int            NS    = 2 ** SW;
   localparam logic [SW-1:0] S_0   = '0;
   localparam logic [SW-1:0] S_HIT = SW'(PAT_W);

   // Entry (2*k + b) holds the successor of state k on input bit b.
   function automatic logic [2*NS*SW-1:0] build_table();
      logic [2*NS*SW-1:0] t;
      t = '0;
      for (int k = 0; k < NS; k++)
         for (int b = 0; b < 2; b++)
            t[(2*k+b)*SW +: SW] = SW'(next_state(MAX_PAT_W'(PATTERN), PAT_W, int'(OVERLAP), k, b));
      return t;
   endfunction

   localparam logic [2*NS*SW-1:0] NEXT_TBL = build_table();

   logic [SW-1:0] state;
   logic [SW-1:0] state_nxt;
   int            tbl_idx;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= S_0;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tbl_idx   = 2 * int'(state) + int'(data);
      if (int'(state) > PAT_W)
         state_nxt = S_0;
      else if (data_valid)
         state_nxt = NEXT_TBL[tbl_idx*SW +: SW];
   end

   assign detected  = (state == S_HIT);
   assign state_dbg = state;

`ifdef SEQ_DET_CNT_EN
   logic hit_entry;

   assign hit_entry = data_valid && (state_nxt == S_HIT);

   seq_det_sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_entry),
      .count (det_count)
   );
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Four detector configurations (1101 / 10101, each non-overlapping and overlapping)
// driven in lockstep and compared against a suffix-matching reference model.
module tb_moore_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_valid = 1'b0;
   logic       data = 1'b0;
   logic       det [4];
   logic [2:0] st  [4];
`ifdef SEQ_DET_CNT_EN
   logic [3:0] cnt [4];
`endif

   int n_vec = 0;
   int n_err = 0;

   int cw [4] = '{4, 4, 5, 5};
   int cp [4] = '{13, 13, 21, 21};
   int co [4] = '{0, 1, 0, 1};

   int hist   [4];
   int hlen   [4];
   int est    [4];
   int ecnt   [4];
   int pulses [4];

   always #5 clk = ~clk;

   moore_seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(4)) u_d0 (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .detected(det[0]), .state_dbg(st[0])
`ifdef SEQ_DET_CNT_EN
      , .det_count(cnt[0])
`endif
   );
   moore_seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(4)) u_d1 (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .detected(det[1]), .state_dbg(st[1])
`ifdef SEQ_DET_CNT_EN
      , .det_count(cnt[1])
`endif
   );
   moore_seq_detector_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1'b0), .CNT_W(4)) u_d2 (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .detected(det[2]), .state_dbg(st[2])
`ifdef SEQ_DET_CNT_EN
      , .det_count(cnt[2])
`endif
   );
   moore_seq_detector_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(4)) u_d3 (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .detected(det[3]), .state_dbg(st[3])
`ifdef SEQ_DET_CNT_EN
      , .det_count(cnt[3])
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Longest j <= PAT_W whose last j received bits equal the first j pattern bits.
   function automatic int longest(input int i);
      int best;
      int m;
      best = 0;
      for (int j = 1; j <= cw[i]; j++) begin
         m = (1 << j) - 1;
         if (j <= hlen[i] && ((hist[i] & m) == ((cp[i] >> (cw[i] - j)) & m))) best = j;
      end
      return best;
   endfunction

   task automatic model_step(input int i, input bit r, input bit v, input bit d);
      if (!r) begin
         hist[i] = 0; hlen[i] = 0; est[i] = 0; ecnt[i] = 0;
      end else if (v) begin
         if (est[i] == cw[i] && co[i] == 0) begin
            hist[i] = 0; hlen[i] = 0;
         end
         hist[i] = ((hist[i] << 1) | int'(d)) & 16'hFFFF;
         hlen[i] = (hlen[i] < cw[i]) ? hlen[i] + 1 : cw[i];
         est[i]  = longest(i);
         if (est[i] == cw[i] && ecnt[i] < 15) ecnt[i]++;
      end
   endtask

   task automatic step(input bit r, input bit v, input bit d);
      @(negedge clk);
      rst = r; data_valid = v; data = d;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         model_step(i, r, v, d);
         check($sformatf("state%0d", i), int'(st[i]), est[i]);
         check($sformatf("det%0d", i), int'(det[i]), (est[i] == cw[i]) ? 1 : 0);
`ifdef SEQ_DET_CNT_EN
         check($sformatf("cnt%0d", i), int'(cnt[i]), ecnt[i]);
`endif
         if (r && v && det[i]) pulses[i]++;
      end
   endtask

   task automatic send_bits(input int n, input int bits);
      for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b1, bits[k]);
   endtask

   task automatic clear_pulses();
      for (int i = 0; i < 4; i++) pulses[i] = 0;
   endtask

   initial begin
      // reset with toggling data
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_state%0d", i), int'(st[i]), 0);

      // 1101101: one hit non-overlapping, two overlapping
      clear_pulses();
      send_bits(7, 'b1101101);
      check("p1101_d0", pulses[0], 1);
      check("p1101_d1", pulses[1], 2);
      check("p1101_d2", pulses[2], 0);

      // self-loop on the border: 111101
      step(1'b0, 1'b0, 1'b0);
      send_bits(6, 'b111101);
      check("t4_det", int'(det[0]), 1);

      // valid gaps mid-sequence and after a hit
      step(1'b0, 1'b0, 1'b0);
      send_bits(2, 'b11);
      for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'($urandom));
      check("gap_hold", int'(st[0]), 2);
      send_bits(2, 'b01);
      check("gap_hit", int'(det[0]), 1);
      step(1'b1, 1'b0, 1'b0);
      check("gap_hit_hold", int'(det[0]), 1);
      send_bits(1, 'b0);
      check("gap_hit_drop", int'(det[0]), 0);

      // mid-sequence reset discards the partial match
      step(1'b0, 1'b0, 1'b0);
      send_bits(3, 'b110);
      step(1'b0, 1'b1, 1'b1);
      send_bits(1, 'b1);
      check("t6_state", int'(st[0]), 1);
      check("t6_det", int'(det[0]), 0);

      // 10101 pattern: 101010101
      step(1'b0, 1'b0, 1'b0);
      clear_pulses();
      send_bits(9, 'b101010101);
      check("p10101_d2", pulses[2], 1);
      check("p10101_d3", pulses[3], 3);
      check("p10101_d0", pulses[0], 0);

      // drive counters into saturation
      step(1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 20; r++) send_bits(4, 'b1101);

      // randomized traffic with occasional resets and valid gaps
      for (int n = 0; n < 3000; n++)
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
